// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 back end: one-time power-up init, then continuous refresh of
// two 32-bit words rendered as 8 uppercase hex characters per line.
module lcd_hex_driver #(
  parameter int PWR_UP_CYC = 750000,
  parameter int EN_HI_CYC  = 16,
  parameter int CMD_CYC    = 2000,
  parameter int CLR_CYC    = 82000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] line1_data,
  input  logic [31:0] line2_data,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        init_done,
  output logic        frame_done
);

  localparam int MAX_A   = (PWR_UP_CYC > CLR_CYC) ? PWR_UP_CYC : CLR_CYC;
  localparam int MAX_B   = (EN_HI_CYC > CMD_CYC) ? EN_HI_CYC : CMD_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_UP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_HI_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, LATCH, SEND, DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t        r_state;
  phase_t        r_phase;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_idx;
  logic [31:0]   r_line1;
  logic [31:0]   r_line2;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_en;
  logic          r_initDone;
  logic          r_frameDone;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] initCmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // {rs, data} of frame byte i; nibbles come from the frame snapshot, MSB first
  function automatic logic [8:0] frameByte(input logic [4:0] i,
                                           input logic [31:0] l1,
                                           input logic [31:0] l2);
    logic [2:0] p;
    p = 3'd0;
    if (i == 5'd0) begin
      return {1'b0, 8'h80};
    end else if (i <= 5'd8) begin
      p = 3'(5'd8 - i);
      return {1'b1, hexChar(l1[{p, 2'b00} +: 4])};
    end else if (i == 5'd9) begin
      return {1'b0, 8'hC0};
    end else begin
      p = 3'(5'd17 - i);
      return {1'b1, hexChar(l2[{p, 2'b00} +: 4])};
    end
  endfunction

  logic [4:0]    w_nextIdx;
  logic [7:0]    w_nextInitCmd;
  logic [8:0]    w_nextFrameByte;
  logic [CW-1:0] w_holdLast;
  logic          w_lastByte;

  assign w_nextIdx       = r_idx + 5'd1;
  assign w_nextInitCmd   = initCmd(w_nextIdx[1:0]);
  assign w_nextFrameByte = frameByte(w_nextIdx, r_line1, r_line2);
  assign w_holdLast      = (!r_rs && r_data == 8'h01) ? CLR_LAST : CMD_LAST;
  assign w_lastByte      = (r_state == INIT) ? (r_idx == 5'd3) : (r_idx == 5'd17);

  // The next byte is loaded on the edge that enters SETUP so data/rs are
  // already valid during the SETUP cycle and stay put until HOLD ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= PWR_WAIT;
      r_phase     <= PH_SETUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_line1     <= '0;
      r_line2     <= '0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_initDone  <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          if (r_cnt == PWR_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_phase <= PH_SETUP;
            r_data  <= 8'h38;
            r_rs    <= 1'b0;
            r_state <= INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (enable) r_state <= LATCH;
        end
        LATCH: begin
          r_line1 <= line1_data;
          r_line2 <= line2_data;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_phase <= PH_SETUP;
          r_data  <= 8'h80;
          r_rs    <= 1'b0;
          r_state <= SEND;
        end
        INIT, SEND: begin
          case (r_phase)
            PH_SETUP: begin
              r_en    <= 1'b1;
              r_cnt   <= '0;
              r_phase <= PH_PULSE;
            end
            PH_PULSE: begin
              if (r_cnt == EN_LAST) begin
                r_en    <= 1'b0;
                r_cnt   <= '0;
                r_phase <= PH_HOLD;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            PH_HOLD: begin
              if (r_cnt == w_holdLast) begin
                r_cnt   <= '0;
                r_phase <= PH_SETUP;
                if (w_lastByte) begin
                  if (r_state == INIT) begin
                    r_initDone <= 1'b1;
                    r_state    <= IDLE;
                  end else begin
                    r_frameDone <= 1'b1;
                    r_state     <= DONE;
                  end
                end else begin
                  r_idx <= w_nextIdx;
                  if (r_state == INIT) begin
                    r_data <= w_nextInitCmd;
                    r_rs   <= 1'b0;
                  end else begin
                    r_data <= w_nextFrameByte[7:0];
                    r_rs   <= w_nextFrameByte[8];
                  end
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: r_phase <= PH_SETUP;
          endcase
        end
        DONE: begin
          r_state <= enable ? LATCH : IDLE;
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

  assign lcd_data   = r_data;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = r_en;
  assign init_done  = r_initDone;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Directed bench for lcd_hex_driver: a bus monitor pops expected bytes from a
// scoreboard queue on every EN rising edge and checks pulse/gap timing.
module tb_lcd_hex_driver;

  localparam int PWR_UP_CYC = 10;
  localparam int EN_HI_CYC  = 2;
  localparam int CMD_CYC    = 4;
  localparam int CLR_CYC    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] line1Data = '0;
  logic [31:0] line2Data = '0;
  logic [7:0]  lcdData;
  logic        lcdRs;
  logic        lcdRw;
  logic        lcdEn;
  logic        initDone;
  logic        frameDone;

  always #5 clock = ~clock;

  lcd_hex_driver #(
    .PWR_UP_CYC(PWR_UP_CYC),
    .EN_HI_CYC (EN_HI_CYC),
    .CMD_CYC   (CMD_CYC),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .line1_data(line1Data),
    .line2_data(line2Data),
    .lcd_data  (lcdData),
    .lcd_rs    (lcdRs),
    .lcd_rw    (lcdRw),
    .lcd_en    (lcdEn),
    .init_done (initDone),
    .frame_done(frameDone)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] expQ[$];
  int         pulseCount = 0;
  int         frameCount = 0;
  int         pulsesSinceReset = 0;

  logic       prevEn = 1'b0;
  logic       prevFrameDone = 1'b0;
  logic       prevInitDone = 1'b0;
  int         highCount = 0;
  int         lowCount = 0;
  int         histCount = 0;
  logic       lastValid = 1'b0;
  logic [8:0] curByte = '0;
  logic [8:0] lastByte = '0;
  logic [8:0] hist1 = '0;
  logic [8:0] hist2 = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] hexModel(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 | {4'h0, n};
    else return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic pushInit();
    expQ.push_back(9'h038);
    expQ.push_back(9'h00C);
    expQ.push_back(9'h001);
    expQ.push_back(9'h006);
  endtask

  task automatic pushFrame(input logic [31:0] l1, input logic [31:0] l2);
    expQ.push_back(9'h080);
    for (int k = 7; k >= 0; k--) expQ.push_back({1'b1, hexModel(l1[k*4 +: 4])});
    expQ.push_back(9'h0C0);
    for (int k = 7; k >= 0; k--) expQ.push_back({1'b1, hexModel(l2[k*4 +: 4])});
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] l1, input logic [31:0] l2);
    enable    = en;
    line1Data = l1;
    line2Data = l2;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitPulses(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (pulseCount < target && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput(tag, pulseCount, target);
  endtask

  task automatic waitFrames(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (frameCount < target && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput(tag, frameCount, target);
  endtask

  task automatic waitInitDone(input int budget, input string tag);
    int c;
    c = 0;
    while (initDone !== 1'b1 && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput(tag, initDone, 1);
  endtask

  // Bus monitor, sampling on the falling edge
  always @(negedge clock) begin : monitor
    logic [8:0] nowByte;
    logic [8:0] expByte;
    nowByte = {lcdRs, lcdData};
    if (reset) begin
      prevEn           = 1'b0;
      prevFrameDone    = 1'b0;
      prevInitDone     = 1'b0;
      highCount        = 0;
      lowCount         = 0;
      histCount        = 0;
      lastValid        = 1'b0;
      pulsesSinceReset = 0;
    end else begin
      if (prevFrameDone) checkOutput("frameDoneWidth", frameDone, 0);
      if (frameDone && !prevFrameDone) begin
        frameCount++;
        checkOutput("frameDoneAfterHold", lowCount, CMD_CYC);
      end
      if (prevInitDone) checkOutput("initDoneSticky", initDone, 1);
      if (initDone && !prevInitDone) begin
        checkOutput("initDoneAfterHold", lowCount, CMD_CYC);
        checkOutput("initPulseTotal", pulsesSinceReset, 4);
      end
      if (lcdEn && !prevEn) begin
        pulseCount++;
        pulsesSinceReset++;
        checkOutput("rwLow", lcdRw, 0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", expQ.size(), 1);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("pulseByte", nowByte, expByte);
        end
        if (histCount >= 1) checkOutput("setupStable", hist1, nowByte);
        if (lastValid && histCount >= 2) checkOutput("holdStable", hist2, lastByte);
        if (lastValid && nowByte != 9'h080)
          checkOutput("gapCycles", lowCount, (lastByte == 9'h001) ? CLR_CYC + 1 : CMD_CYC + 1);
        curByte   = nowByte;
        highCount = 1;
        lowCount  = 0;
      end else if (lcdEn && prevEn) begin
        highCount++;
        checkOutput("pulseStable", nowByte, curByte);
      end else if (!lcdEn && prevEn) begin
        checkOutput("pulseWidth", highCount, EN_HI_CYC);
        checkOutput("fallStable", nowByte, curByte);
        lastByte  = curByte;
        lastValid = 1'b1;
        lowCount  = 1;
      end else begin
        lowCount++;
      end
      hist2         = hist1;
      hist1         = nowByte;
      histCount++;
      prevEn        = lcdEn;
      prevFrameDone = frameDone;
      prevInitDone  = initDone;
    end
  end

  initial begin
    int base;
    applyStimulus(1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick(3);
    @(negedge clock);
    checkOutput("rstData", lcdData, 8'h00);
    checkOutput("rstRs", lcdRs, 0);
    checkOutput("rstRw", lcdRw, 0);
    checkOutput("rstEn", lcdEn, 0);
    checkOutput("rstInitDone", initDone, 0);
    checkOutput("rstFrameDone", frameDone, 0);

    // Power-up and init with enable low
    tick(1);
    pushInit();
    reset = 1'b0;
    for (int i = 0; i < PWR_UP_CYC; i++) begin
      @(negedge clock);
      checkOutput("pwrWaitEnLow", lcdEn, 0);
    end
    tick(1);
    waitPulses(4, 300, "initPulseCount");
    waitInitDone(100, "initDone");
    tick(40);
    checkOutput("noPulseAfterInit", pulseCount, 4);
    checkOutput("initQueueEmpty", expQ.size(), 0);

    // Reference frame with the literal character table
    base = pulseCount;
    expQ.push_back(9'h080);
    expQ.push_back(9'h130); expQ.push_back(9'h130); expQ.push_back(9'h134); expQ.push_back(9'h130);
    expQ.push_back(9'h130); expQ.push_back(9'h130); expQ.push_back(9'h141); expQ.push_back(9'h143);
    expQ.push_back(9'h0C0);
    expQ.push_back(9'h144); expQ.push_back(9'h145); expQ.push_back(9'h141); expQ.push_back(9'h144);
    expQ.push_back(9'h142); expQ.push_back(9'h145); expQ.push_back(9'h145); expQ.push_back(9'h146);
    applyStimulus(1'b1, 32'h004000AC, 32'hDEADBEEF);
    waitPulses(base + 1, 100, "frame1Start");
    enable = 1'b0;
    waitFrames(1, 600, "frame1Done");
    tick(40);
    checkOutput("frame1Pulses", pulseCount, base + 18);
    checkOutput("frame1QueueEmpty", expQ.size(), 0);
    checkOutput("frame1Count", frameCount, 1);

    // Input change mid-frame only affects the following back-to-back frame
    base = pulseCount;
    pushFrame(32'h11111111, 32'h0123ABCD);
    pushFrame(32'h22222222, 32'h0123ABCD);
    applyStimulus(1'b1, 32'h11111111, 32'h0123ABCD);
    waitPulses(base + 4, 100, "snapIdx3");
    line1Data = 32'h22222222;
    waitPulses(base + 19, 600, "backToBackStart");
    enable = 1'b0;
    waitFrames(3, 600, "snapFramesDone");
    tick(40);
    checkOutput("snapPulses", pulseCount, base + 36);
    checkOutput("snapQueueEmpty", expQ.size(), 0);

    // enable dropped during index 10, then re-raised without re-init
    base = pulseCount;
    pushFrame(32'hCAFEF00D, 32'h13579BDF);
    applyStimulus(1'b1, 32'hCAFEF00D, 32'h13579BDF);
    waitPulses(base + 11, 400, "dropIdx10");
    enable = 1'b0;
    waitFrames(4, 600, "dropFrameDone");
    tick(60);
    checkOutput("dropNoMorePulses", pulseCount, base + 18);
    checkOutput("dropQueueEmpty", expQ.size(), 0);
    checkOutput("dropInitDoneHeld", initDone, 1);
    base = pulseCount;
    pushFrame(32'h89ABCDEF, 32'h76543210);
    applyStimulus(1'b1, 32'h89ABCDEF, 32'h76543210);
    waitPulses(base + 1, 100, "resumeStart");
    enable = 1'b0;
    waitFrames(5, 600, "resumeFrameDone");
    tick(20);
    checkOutput("resumePulses", pulseCount, base + 18);
    checkOutput("resumeQueueEmpty", expQ.size(), 0);

    // Reset while EN is high restarts power-up wait and init
    base = pulseCount;
    pushFrame(32'hA5A5A5A5, 32'h5A5A5A5A);
    applyStimulus(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    waitPulses(base + 3, 200, "resetTarget");
    checkOutput("enHighAtReset", lcdEn, 1);
    reset  = 1'b1;
    enable = 1'b0;
    expQ.delete();
    pushInit();
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("resetEnLow", lcdEn, 0);
    checkOutput("resetInitDone", initDone, 0);
    for (int i = 1; i < PWR_UP_CYC; i++) begin
      @(negedge clock);
      checkOutput("rePwrWaitEnLow", lcdEn, 0);
    end
    tick(1);
    base = pulseCount;
    waitPulses(base + 4, 300, "reInitPulses");
    waitInitDone(100, "reInitDone");
    tick(40);
    checkOutput("reInitNoMore", pulseCount, base + 4);
    checkOutput("reInitQueueEmpty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hex_driver.md
Name: lcd_hex_driver

Overview:
- Character-LCD back end for the debug display path.
- Consumes the two 32-bit words selected by the data-select stage and renders each as 8 uppercase hex characters: line 1 from line1_data, line 2 from line2_data.
- Drives the HD44780-compatible 16x2 panel directly: runs the power-up init sequence once, then refreshes both lines continuously while enabled.

Parameters:
- PWR_UP_CYC, 750000: clock cycles to wait after reset before the first command (15 ms at 50 MHz).
- EN_HI_CYC, 16: width of the lcd_en high pulse, in cycles.
- CMD_CYC, 2000: cycles lcd_en stays low after each write, except clear (40 us).
- CLR_CYC, 82000: cycles lcd_en stays low after the clear command 0x01 (1.64 ms).

Ports:
- clock  in  1  system clock (CLOCK_50 domain); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new refresh frames to start.
- line1_data  in  32  word shown on LCD line 1.
- line2_data  in  32  word shown on LCD line 2.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  register select: 0 = command, 1 = character.
- lcd_rw  out  1  tied to 0; write-only, busy flag never read.
- lcd_en  out  1  LCD enable strobe.
- init_done  out  1  high once the init sequence has completed.
- frame_done  out  1  one-cycle pulse at the end of each refresh frame.

Behaviour:
- Reset values: lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, init_done=0, frame_done=0, FSM in PWR_WAIT, all counters cleared.
- Reset mid-operation: on the cycle after reset is sampled high, lcd_en=0 regardless of state. The full power-up wait and init sequence always repeat.
- Byte write transaction, identical for every byte:
  - SETUP: 1 cycle. lcd_data and lcd_rs are driven, lcd_en=0.
  - PULSE: EN_HI_CYC cycles with lcd_en=1.
  - HOLD: lcd_en=0 for CMD_CYC cycles, or CLR_CYC if the byte is command 0x01.
  - lcd_data and lcd_rs hold their values from SETUP through the end of HOLD.
  - Minimum low gap between two EN pulses is therefore CMD_CYC+1 cycles.
- FSM states: PWR_WAIT, INIT, IDLE, LATCH, SEND, DONE.
- PWR_WAIT: counts PWR_UP_CYC cycles with lcd_en=0, then goes to INIT.
- INIT: writes commands 0x38, 0x0C, 0x01, 0x06 in that order, all with rs=0. After the HOLD of 0x06, init_done goes to 1 and the FSM goes to IDLE. init_done stays 1 until reset.
- IDLE: if enable=1, go to LATCH; otherwise stay. Outputs hold; lcd_en=0.
- LATCH: 1 cycle. Snapshots line1_data and line2_data into internal registers, then goes to SEND. Input changes during a frame do not affect that frame.
- SEND: 18 byte writes using the snapshot values:
  - index 0: command 0x80, rs=0.
  - index 1-8: line1 nibbles [31:28] down to [3:0], rs=1.
  - index 9: command 0xC0, rs=0.
  - index 10-17: line2 nibbles, MSB nibble first, rs=1.
- Hex encoding: nibble 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46 (uppercase).
- DONE: frame_done=1 for exactly 1 cycle on the cycle after the HOLD of index 17 ends.
  - If enable=1 at that cycle, the next cycle is LATCH (back-to-back frames).
  - Otherwise the next state is IDLE.
- enable low mid-frame: the current frame completes normally, including frame_done. enable has no effect during PWR_WAIT or INIT.
- Counters must be wide enough for max(PWR_UP_CYC, CLR_CYC). Counters never wrap within a single wait.

Test Plan:
Directed tests use PWR_UP_CYC=10, EN_HI_CYC=2, CMD_CYC=4, CLR_CYC=8.
1. Release reset with enable=0:
   - lcd_en stays 0 for 10 cycles.
   - EN pulses then carry 0x38, 0x0C, 0x01, 0x06 with rs=0, each pulse exactly 2 cycles wide.
   - init_done rises after the last HOLD; no further pulses follow.
2. line1=0x004000AC, line2=0xDEADBEEF, enable=1 → 18 pulses carrying:
   - 0x80
   - 0x30 0x30 0x34 0x30 0x30 0x30 0x41 0x43
   - 0xC0
   - 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46
   - rs=0 only on 0x80 and 0xC0; frame_done pulses once, 1 cycle wide.
3. Gap timing:
   - lcd_en low gap after 0x01 = 9 cycles.
   - Gap after every other byte = 5 cycles.
   - lcd_data is stable from SETUP to the end of HOLD.
4. Change line1 from 0x11111111 to 0x22222222 during index 3 of a frame → that frame shows all 0x31 characters; the next frame shows all 0x32.
5. Drop enable during index 10 → frame finishes, frame_done pulses, no pulses afterwards. Raise enable → next frame begins with 0x80, with no re-init.
6. Assert reset for 1 cycle while lcd_en=1 during a frame:
   - lcd_en=0 and init_done=0 on the following cycle.
   - 10-cycle wait, then 0x38 is the first byte again.
